regfile_wb_arbiter: RTL and testbench

Write-port arbiter and busy-register scoreboard in front of the single write port of the 32x32 register file. It shares that port between the in-order ALU writeback and the long-latency load/store unit (LSU), and drives the file's RegWrEn/WriteReg/WriteData from a registered stage. It tracks destinations reserved by in-flight LSU operations and flags read hazards to the issue stage.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arb2.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file parameters and the write-port requester encoding.
package regfile_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned NREG = 2 ** AW;

   // Requester index; also the bit position in the eligible/grant vectors.
   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LSU = 1'b1
   } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a registered last-grant pointer.
// On a tie the requester that was not granted last wins; the pointer only
// moves when something is granted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] eligible,
   output logic [1:0] grant
);

   import regfile_pkg::*;

   req_e last_q;
   req_e last_d;

   // One-hot grant from eligibility and the last winner.
   always_comb begin
      grant = 2'b00;
      case (eligible)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_q == REQ_LSU) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Pointer follows the winner; holds when idle.
   always_comb begin
      last_d = last_q;
      if (grant[REQ_LSU]) begin
         last_d = REQ_LSU;
      end else if (grant[REQ_ALU]) begin
         last_d = REQ_ALU;
      end
   end

   // Reset to "LSU last" so the ALU wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= REQ_LSU;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter and busy-register scoreboard for the 32x32 register file.
// Shares the single write port between ALU writeback and the LSU, drives the
// port from a registered stage, and tracks LSU-reserved destinations.
module regfile_wb_arbiter #(
   parameter int unsigned XLEN = regfile_pkg::XLEN,
   parameter int unsigned AW   = regfile_pkg::AW,
   parameter int unsigned NREG = regfile_pkg::NREG
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            AluWrValid,
   input  logic [AW-1:0]   AluWrReg,
   input  logic [XLEN-1:0] AluWrData,
   output logic            AluWrReady,
   input  logic            LsuWrValid,
   input  logic [AW-1:0]   LsuWrReg,
   input  logic [XLEN-1:0] LsuWrData,
   output logic            LsuWrReady,
   input  logic            RsvValid,
   input  logic [AW-1:0]   RsvReg,
   output logic            RsvReady,
   input  logic [AW-1:0]   ReadReg1,
   input  logic [AW-1:0]   ReadReg2,
   output logic            Hazard1,
   output logic            Hazard2,
   output logic            RegWrEn,
   output logic [AW-1:0]   WriteReg,
   output logic [XLEN-1:0] WriteData,
   output logic            ProtoErr
);

   import regfile_pkg::*;

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            proto_err_q;
   logic            proto_err_d;
   logic            wen_q;
   logic [AW-1:0]   wreg_q;
   logic [XLEN-1:0] wdata_q;

   logic            alu_elig;
   logic [1:0]      eligible;
   logic [1:0]      grant;
   logic            alu_acc;
   logic            lsu_acc;
   logic            rsv_acc;
   logic [AW-1:0]   win_reg;
   logic [XLEN-1:0] win_data;

   // ALU stalls while its destination still awaits an older LSU write (WAW);
   // x0 is never busy so it is always eligible.
   assign alu_elig = AluWrValid & ((AluWrReg == '0) | ~busy_q[AluWrReg]);

   // Build the eligible vector indexed by requester.
   always_comb begin
      eligible          = 2'b00;
      eligible[REQ_ALU] = alu_elig;
      eligible[REQ_LSU] = LsuWrValid;
   end

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .eligible (eligible),
      .grant    (grant)
   );

   assign alu_acc    = grant[REQ_ALU];
   assign lsu_acc    = grant[REQ_LSU];
   assign AluWrReady = alu_acc;
   assign LsuWrReady = lsu_acc;

   // A busy destination refuses a new reservation, including one whose
   // clearing LSU write lands this same cycle.
   assign rsv_acc  = RsvValid & ~busy_q[RsvReg];
   assign RsvReady = rsv_acc;

   assign win_reg  = lsu_acc ? LsuWrReg  : AluWrReg;
   assign win_data = lsu_acc ? LsuWrData : AluWrData;

   // Scoreboard next state: LSU write clears, reservation sets, x0 never busy.
   always_comb begin
      busy_d = busy_q;
      if (lsu_acc) begin
         busy_d[LsuWrReg] = 1'b0;
      end
      if (rsv_acc) begin
         busy_d[RsvReg] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Sticky flag for an LSU write to a register that was never reserved.
   always_comb begin
      proto_err_d = proto_err_q;
      if (lsu_acc && (LsuWrReg != '0) && !busy_q[LsuWrReg]) begin
         proto_err_d = 1'b1;
      end
   end

   // Scoreboard and error state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         proto_err_q <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Registered write-port stage; an x0 winner is consumed without enabling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen_q   <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
      end else if (|grant) begin
         wen_q   <= (win_reg != '0);
         wreg_q  <= win_reg;
         wdata_q <= win_data;
      end else begin
         wen_q   <= 1'b0;
      end
   end

   assign RegWrEn   = wen_q;
   assign WriteReg  = wreg_q;
   assign WriteData = wdata_q;
   assign ProtoErr  = proto_err_q;
   assign Hazard1   = busy_q[ReadReg1];
   assign Hazard2   = busy_q[ReadReg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, a reset-mid-operation
// sequence, then randomized traffic against a behavioural scoreboard model.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        AluWrValid;
   logic [4:0]  AluWrReg;
   logic [31:0] AluWrData;
   logic        AluWrReady;
   logic        LsuWrValid;
   logic [4:0]  LsuWrReg;
   logic [31:0] LsuWrData;
   logic        LsuWrReady;
   logic        RsvValid;
   logic [4:0]  RsvReg;
   logic        RsvReady;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic        Hazard1;
   logic        Hazard2;
   logic        RegWrEn;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        ProtoErr;

   int checks;
   int failures;

   regfile_wb_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .AluWrValid (AluWrValid),
      .AluWrReg   (AluWrReg),
      .AluWrData  (AluWrData),
      .AluWrReady (AluWrReady),
      .LsuWrValid (LsuWrValid),
      .LsuWrReg   (LsuWrReg),
      .LsuWrData  (LsuWrData),
      .LsuWrReady (LsuWrReady),
      .RsvValid   (RsvValid),
      .RsvReg     (RsvReg),
      .RsvReady   (RsvReady),
      .ReadReg1   (ReadReg1),
      .ReadReg2   (ReadReg2),
      .Hazard1    (Hazard1),
      .Hazard2    (Hazard2),
      .RegWrEn    (RegWrEn),
      .WriteReg   (WriteReg),
      .WriteData  (WriteData),
      .ProtoErr   (ProtoErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        alu_v;
      logic [4:0]  alu_reg;
      logic [31:0] alu_data;
      logic        lsu_v;
      logic [4:0]  lsu_reg;
      logic [31:0] lsu_data;
      logic        rsv_v;
      logic [4:0]  rsv_reg;
      logic [4:0]  rd1;
      logic [4:0]  rd2;
      logic        e_alu;
      logic        e_lsu;
      logic        e_rsv;
      logic        e_hz1;
      logic        e_hz2;
      logic        e_wen;
      logic [4:0]  e_wreg;
      logic [31:0] e_wdata;
      logic        e_perr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t row(input int rst, input int av, input int ar, input int ad,
                                input int lv, input int lr, input int ld, input int rv,
                                input int rr, input int r1, input int r2, input int ea,
                                input int el, input int er, input int h1, input int h2,
                                input int ew, input int ewr, input int ewd, input int ep);
      vec_t v;
      v.rst = 1'(rst);   v.alu_v = 1'(av);   v.alu_reg = 5'(ar);  v.alu_data = 32'(ad);
      v.lsu_v = 1'(lv);  v.lsu_reg = 5'(lr); v.lsu_data = 32'(ld);
      v.rsv_v = 1'(rv);  v.rsv_reg = 5'(rr); v.rd1 = 5'(r1);      v.rd2 = 5'(r2);
      v.e_alu = 1'(ea);  v.e_lsu = 1'(el);   v.e_rsv = 1'(er);
      v.e_hz1 = 1'(h1);  v.e_hz2 = 1'(h2);   v.e_wen = 1'(ew);
      v.e_wreg = 5'(ewr); v.e_wdata = 32'(ewd); v.e_perr = 1'(ep);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      AluWrValid = 1'b0; AluWrReg = '0; AluWrData = '0;
      LsuWrValid = 1'b0; LsuWrReg = '0; LsuWrData = '0;
      RsvValid   = 1'b0; RsvReg   = '0;
      ReadReg1   = '0;   ReadReg2 = '0;
   endtask

   // Behavioural model state for the random phase.
   bit          busy_m[32];
   bit          alu_last_m;
   bit          perr_m;
   bit          wen_m;
   logic [4:0]  wreg_m;
   logic [31:0] wdata_m;

   task automatic model_reset();
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      alu_last_m = 1'b0;
      perr_m     = 1'b0;
      wen_m      = 1'b0;
      wreg_m     = '0;
      wdata_m    = '0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      set_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      ReadReg1 = 5'd5;
      ReadReg2 = 5'd31;
      #1;
      check("reset.RegWrEn",   32'(RegWrEn),   32'd0);
      check("reset.WriteReg",  32'(WriteReg),  32'd0);
      check("reset.WriteData", WriteData,      32'd0);
      check("reset.ProtoErr",  32'(ProtoErr),  32'd0);
      check("reset.Hazard1",   32'(Hazard1),   32'd0);
      check("reset.Hazard2",   32'(Hazard2),   32'd0);
      rst_n = 1'b1;

      // rst alu(v,reg,data) lsu(v,reg,data) rsv(v,reg) rd1 rd2 | alu lsu rsv hz1 hz2 wen wreg wdata perr
      vecs.push_back(row(1, 0,0,0,           0,0,0,            1,2, 0,0, 0,0,1,0,0, 0,0,0,      0));
      vecs.push_back(row(0, 0,0,0,           0,0,0,            1,4, 2,4, 0,0,1,1,0, 0,0,0,      0));
      vecs.push_back(row(0, 1,1,'h11,        1,2,'h22,         0,0, 2,4, 1,0,0,1,1, 0,0,0,      0));
      vecs.push_back(row(0, 1,3,'h33,        1,2,'h22,         0,0, 2,4, 0,1,0,1,1, 1,1,'h11,   0));
      vecs.push_back(row(0, 1,3,'h33,        1,4,'h44,         0,0, 2,4, 1,0,0,0,1, 1,2,'h22,   0));
      vecs.push_back(row(0, 1,6,'h66,        1,4,'h44,         0,0, 2,4, 0,1,0,0,1, 1,3,'h33,   0));
      vecs.push_back(row(0, 1,6,'h66,        0,0,0,            0,0, 2,4, 1,0,0,0,0, 1,4,'h44,   0));
      vecs.push_back(row(0, 0,0,0,           0,0,0,            0,0, 2,4, 0,0,0,0,0, 1,6,'h66,   0));
      vecs.push_back(row(0, 0,0,0,           0,0,0,            0,0, 0,0, 0,0,0,0,0, 0,6,'h66,   0));
      // WAW stall on x7 until the LSU delivers 0xBEEF
      vecs.push_back(row(0, 0,0,0,           0,0,0,            1,7, 7,0, 0,0,1,0,0, 0,6,'h66,   0));
      vecs.push_back(row(0, 1,7,'h77,        0,0,0,            1,7, 7,0, 0,0,0,1,0, 0,6,'h66,   0));
      vecs.push_back(row(0, 1,7,'h77,        1,7,'hBEEF,       1,7, 7,0, 0,1,0,1,0, 0,6,'h66,   0));
      vecs.push_back(row(0, 1,7,'h77,        0,0,0,            1,7, 7,0, 1,0,1,0,0, 1,7,'hBEEF, 0));
      vecs.push_back(row(0, 0,0,0,           0,0,0,            0,0, 7,0, 0,0,0,1,0, 1,7,'h77,   0));
      vecs.push_back(row(0, 0,0,0,           1,7,'h7777,       0,0, 7,0, 0,1,0,1,0, 0,7,'h77,   0));
      vecs.push_back(row(0, 0,0,0,           0,0,0,            0,0, 7,0, 0,0,0,0,0, 1,7,'h7777, 0));
      // x0 write and x0 reservation
      vecs.push_back(row(0, 1,0,'hFFFF,      0,0,0,            1,0, 0,0, 1,0,1,0,0, 0,7,'h7777, 0));
      vecs.push_back(row(0, 0,0,0,           0,0,0,            0,0, 0,0, 0,0,0,0,0, 0,0,'hFFFF, 0));
      // LSU write to unreserved x9
      vecs.push_back(row(0, 0,0,0,           1,9,'h99,         0,0, 9,0, 0,1,0,0,0, 0,0,'hFFFF, 0));
      vecs.push_back(row(0, 0,0,0,           0,0,0,            0,0, 9,0, 0,0,0,0,0, 1,9,'h99,   1));
      vecs.push_back(row(0, 0,0,0,           0,0,0,            0,0, 0,0, 0,0,0,0,0, 0,9,'h99,   1));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         if (vecs[i].rst) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
         end
         AluWrValid = vecs[i].alu_v; AluWrReg = vecs[i].alu_reg; AluWrData = vecs[i].alu_data;
         LsuWrValid = vecs[i].lsu_v; LsuWrReg = vecs[i].lsu_reg; LsuWrData = vecs[i].lsu_data;
         RsvValid   = vecs[i].rsv_v; RsvReg   = vecs[i].rsv_reg;
         ReadReg1   = vecs[i].rd1;   ReadReg2 = vecs[i].rd2;
         #1;
         check($sformatf("row%0d.AluWrReady", i), 32'(AluWrReady), 32'(vecs[i].e_alu));
         check($sformatf("row%0d.LsuWrReady", i), 32'(LsuWrReady), 32'(vecs[i].e_lsu));
         check($sformatf("row%0d.RsvReady", i),   32'(RsvReady),   32'(vecs[i].e_rsv));
         check($sformatf("row%0d.Hazard1", i),    32'(Hazard1),    32'(vecs[i].e_hz1));
         check($sformatf("row%0d.Hazard2", i),    32'(Hazard2),    32'(vecs[i].e_hz2));
         check($sformatf("row%0d.RegWrEn", i),    32'(RegWrEn),    32'(vecs[i].e_wen));
         check($sformatf("row%0d.WriteReg", i),   32'(WriteReg),   32'(vecs[i].e_wreg));
         check($sformatf("row%0d.WriteData", i),  WriteData,       vecs[i].e_wdata);
         check($sformatf("row%0d.ProtoErr", i),   32'(ProtoErr),   32'(vecs[i].e_perr));
      end

      // Reset asserted while a write is on the port, x3 busy and ProtoErr set.
      @(negedge clk);
      set_idle();
      RsvValid = 1'b1; RsvReg = 5'd3;
      AluWrValid = 1'b1; AluWrReg = 5'd1; AluWrData = 32'hAB;
      #1;
      check("rstmid.AluWrReady", 32'(AluWrReady), 32'd1);
      check("rstmid.RsvReady",   32'(RsvReady),   32'd1);
      @(negedge clk);
      set_idle();
      ReadReg1 = 5'd3;
      #1;
      check("rstmid.pre.RegWrEn",  32'(RegWrEn),  32'd1);
      check("rstmid.pre.WriteReg", 32'(WriteReg), 32'd1);
      check("rstmid.pre.Hazard1",  32'(Hazard1),  32'd1);
      check("rstmid.pre.ProtoErr", 32'(ProtoErr), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstmid.RegWrEn",   32'(RegWrEn),  32'd0);
      check("rstmid.Hazard1",   32'(Hazard1),  32'd0);
      check("rstmid.ProtoErr",  32'(ProtoErr), 32'd0);
      check("rstmid.WriteData", WriteData,     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      AluWrValid = 1'b1; AluWrReg = 5'd10; AluWrData = 32'h1010;
      LsuWrValid = 1'b1; LsuWrReg = 5'd0;  LsuWrData = 32'h2;
      #1;
      check("rstmid.tie1.AluWrReady", 32'(AluWrReady), 32'd1);
      check("rstmid.tie1.LsuWrReady", 32'(LsuWrReady), 32'd0);
      @(negedge clk);
      #1;
      check("rstmid.tie2.AluWrReady", 32'(AluWrReady), 32'd0);
      check("rstmid.tie2.LsuWrReady", 32'(LsuWrReady), 32'd1);
      check("rstmid.tie2.WriteData",  WriteData,       32'h1010);
      check("rstmid.tie2.RegWrEn",    32'(RegWrEn),    32'd1);

      // Randomized traffic against the scoreboard model.
      @(negedge clk);
      set_idle();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [4:0] busy_list[$];
         bit         alu_ok;
         bit         lsu_ok;
         bit         rsv_ok;
         int         win;
         @(negedge clk);
         if (cyc % 1000 == 999) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
            model_reset();
         end
         busy_list.delete();
         for (int r = 1; r < 32; r++) if (busy_m[r]) busy_list.push_back(5'(r));
         AluWrValid = ($urandom_range(0, 9) < 6);
         AluWrReg   = 5'($urandom_range(0, 7));
         AluWrData  = $urandom();
         LsuWrValid = ($urandom_range(0, 9) < 4);
         if (busy_list.size() != 0 && $urandom_range(0, 3) != 0)
            LsuWrReg = busy_list[$urandom_range(0, busy_list.size() - 1)];
         else
            LsuWrReg = 5'($urandom_range(0, 7));
         LsuWrData  = $urandom();
         RsvValid   = ($urandom_range(0, 9) < 4);
         RsvReg     = 5'($urandom_range(0, 7));
         ReadReg1   = 5'($urandom_range(0, 7));
         ReadReg2   = 5'($urandom_range(0, 31));
         #1;
         alu_ok = AluWrValid && (AluWrReg == 5'd0 || !busy_m[AluWrReg]);
         lsu_ok = LsuWrValid;
         rsv_ok = RsvValid && !busy_m[RsvReg];
         if (alu_ok && lsu_ok) win = alu_last_m ? 2 : 1;
         else if (alu_ok)      win = 1;
         else if (lsu_ok)      win = 2;
         else                  win = 0;
         check("rnd.AluWrReady", 32'(AluWrReady), 32'(win == 1));
         check("rnd.LsuWrReady", 32'(LsuWrReady), 32'(win == 2));
         check("rnd.RsvReady",   32'(RsvReady),   32'(rsv_ok));
         check("rnd.Hazard1",    32'(Hazard1),    32'(busy_m[ReadReg1]));
         check("rnd.Hazard2",    32'(Hazard2),    32'(busy_m[ReadReg2]));
         check("rnd.RegWrEn",    32'(RegWrEn),    32'(wen_m));
         check("rnd.ProtoErr",   32'(ProtoErr),   32'(perr_m));
         if (wen_m) begin
            check("rnd.WriteReg",  32'(WriteReg), 32'(wreg_m));
            check("rnd.WriteData", WriteData,     wdata_m);
         end
         // Advance the model across the coming rising edge.
         if (win == 1) begin
            wen_m = (AluWrReg != 5'd0); wreg_m = AluWrReg; wdata_m = AluWrData;
            alu_last_m = 1'b1;
         end else if (win == 2) begin
            wen_m = (LsuWrReg != 5'd0); wreg_m = LsuWrReg; wdata_m = LsuWrData;
            alu_last_m = 1'b0;
            if (LsuWrReg != 5'd0 && !busy_m[LsuWrReg]) perr_m = 1'b1;
            busy_m[LsuWrReg] = 1'b0;
         end else begin
            wen_m = 1'b0;
         end
         if (rsv_ok && RsvReg != 5'd0) busy_m[RsvReg] = 1'b1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
